// File: rtl/serial_magnitude_comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmp_pkg
// Description : Shared types and constants for serial_magnitude_comparator.
//               - state_t : FSM state encoding (IDLE, CMP)
//               - RES_EQ / RES_GT / RES_LT : one-hot {eq, gt, lt} encodings
// Revision    : 1.0 - initial release
// ============================================================================
package serial_cmp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Result vector ordering is {eq, gt, lt}
    localparam logic [2:0] RES_EQ = 3'b100;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

endpackage
`default_nettype wire

// File: rtl/serial_magnitude_comparator_digit_compare.sv
`default_nettype none
// ============================================================================
// Module      : digit_compare
// Description : Purely combinational DIGIT-bit unsigned comparator.
// Ports       : a, b    - DIGIT-bit digits to compare
//               dig_eq  - a == b
//               dig_gt  - a >  b
// Revision    : 1.0 - initial release
// ============================================================================
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             dig_eq,
    output logic             dig_gt
);

    assign dig_eq = (a == b);
    assign dig_gt = (a > b);

endmodule
`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_magnitude_comparator
// Description : Multi-cycle WIDTH-bit magnitude comparator scanning DIGIT bits
//               per clock, MSB first, unsigned or two's-complement per op.
// Ports       : clk, rst_n (sync, active-low)
//               start, a, b, signed_mode - request; captured in IDLE only
//               busy - high while in CMP
//               done - one-cycle pulse; eq/gt/lt valid and held until next
// Config      : SERIAL_CMP_EARLY_EXIT_EN defined   -> finish on first
//               differing digit (1..NDIG cycles).
//               SERIAL_CMP_EARLY_EXIT_EN undefined -> always NDIG cycles,
//               first difference held in a sticky register.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("serial_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done;
    logic               r_eq;
    logic               r_gt;
    logic               r_lt;

    logic               w_dig_eq;
    logic               w_dig_gt;
    logic               w_last;
    logic               w_finish;
    logic               w_res_eq;
    logic               w_res_gt;

    // Operands shift left one digit per CMP cycle, so the digit under test
    // is always the top DIGIT bits and no index mux is needed.
    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit_compare (
        .a      (r_a[WIDTH-1 -: DIGIT]),
        .b      (r_b[WIDTH-1 -: DIGIT]),
        .dig_eq (w_dig_eq),
        .dig_gt (w_dig_gt)
    );

    assign w_last = (r_idx == IDX_W'(NDIG - 1));

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    // The first differing digit decides; equal digits up to the last one
    // mean the operands are equal.
    assign w_finish = !w_dig_eq || w_last;
    assign w_res_eq = w_dig_eq;
    assign w_res_gt = w_dig_gt;
`else
    logic r_decided;
    logic r_dec_gt;

    // Sticky record of the first differing digit; later digits are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_decided <= 1'b0;
            r_dec_gt  <= 1'b0;
        end else if (r_state == IDLE) begin
            r_decided <= 1'b0;
            r_dec_gt  <= 1'b0;
        end else if (!r_decided && !w_dig_eq) begin
            r_decided <= 1'b1;
            r_dec_gt  <= w_dig_gt;
        end
    end

    assign w_finish = w_last;
    assign w_res_eq = !r_decided && w_dig_eq;
    assign w_res_gt = r_decided ? r_dec_gt : w_dig_gt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Flipping the sign bit maps two's complement order
                        // onto unsigned order, so the engine stays unsigned.
                        r_a     <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
                        r_b     <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
                        r_idx   <= '0;
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    if (w_finish) begin
                        r_done  <= 1'b1;
                        r_eq    <= w_res_eq;
                        r_gt    <= !w_res_eq && w_res_gt;
                        r_lt    <= !w_res_eq && !w_res_gt;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        r_a   <= r_a << DIGIT;
                        r_b   <= r_b << DIGIT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == CMP);
    assign done = r_done;
    assign eq   = r_eq;
    assign gt   = r_gt;
    assign lt   = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_magnitude_comparator
// Description : Self-checking bench for serial_magnitude_comparator
//               (WIDTH=16, DIGIT=4). Expected {eq,gt,lt} and latency are
//               queued on each accepted start and checked on each done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_magnitude_comparator;
    import serial_cmp_pkg::*;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    serial_magnitude_comparator #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .gt          (gt),
        .lt          (lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] res;
        int         lat;
        int         start_cyc;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sm;
        logic [2:0]       res;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Index of the first differing digit (MSB first), or NDIG-1 if equal.
    function automatic int first_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int i = 0; i < NDIG; i++) begin
            if (d[WIDTH-1-i*DIGIT -: DIGIT] != '0) return i;
        end
        return NDIG - 1;
    endfunction

    function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return first_diff(x, y) + 1;
`else
        return (first_diff(x, y) >= 0) ? NDIG : NDIG;
`endif
    endfunction

    // Scoreboard checker: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with no operation pending, expected done=0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("result_eq_gt_lt", int'({eq, gt, lt}), int'(mon_e.res));
                chk("latency_cycles", cyc - mon_e.start_cyc, mon_e.lat);
            end
        end
    end

    // Called at a negedge: drive a request and queue its expectation.
    task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vsm, input logic [2:0] res);
        exp_t e;
        start       = 1'b1;
        a           = va;
        b           = vb;
        signed_mode = vsm;
        e.res       = res;
        e.lat       = exp_lat(va, vb);
        e.start_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    // Returns at the negedge where done is high, bounded.
    task automatic wait_done(input string name);
        int seen;
        seen = 0;
        for (int t = 0; t < 4 * NDIG + 4; t++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, 4 * NDIG + 4);
        end
    endtask

    vec_t vecs[10];

    initial begin
        int busy_ok;
        int hold_ok;
        int seen_done;

        vecs[0] = '{16'h1234, 16'h1234, 1'b0, RES_EQ};
        vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, RES_GT};
        vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, RES_LT};
        vecs[3] = '{16'h00F0, 16'h00F1, 1'b0, RES_LT};
        vecs[4] = '{16'hFFFE, 16'hFFFF, 1'b1, RES_LT};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, RES_LT};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, RES_EQ};
        vecs[7] = '{16'h7FFF, 16'h8000, 1'b1, RES_GT};
        vecs[8] = '{16'h0100, 16'h00FF, 1'b0, RES_GT};
        vecs[9] = '{16'h8000, 16'h8000, 1'b1, RES_EQ};

        rst_n       = 1'b0;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({busy, done, eq, gt, lt}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", int'(busy), 0);

        // Table-driven single operations
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res);
            @(negedge clk);
            start = 1'b0;
            if (!done) chk("busy_after_start", int'(busy), 1);
            wait_done("vector");
            @(negedge clk);
            chk("done_one_cycle", int'(done), 0);
        end

        // Start while busy: second request must be dropped
        issue(16'h0001, 16'h0002, 1'b0, RES_LT);
        @(negedge clk);
        start       = 1'b1;
        a           = 16'hFFFF;
        b           = 16'h0000;
        signed_mode = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        busy_ok = 1;
        for (int t = 0; t < 4 * NDIG; t++) begin
            if (done) break;
            if (!busy) busy_ok = 0;
            @(negedge clk);
        end
        chk("busy_continuous", busy_ok, 1);
        wait_done("start_while_busy");
        repeat (6) @(negedge clk);
        chk("hold_after_ignored_start", int'({eq, gt, lt}), int'(RES_LT));
        chk("idle_after_ignored_start", int'(busy), 0);

        // Back-to-back: new start in the done cycle, old result held while busy
        issue(16'h1234, 16'h1234, 1'b0, RES_EQ);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first");
        issue(16'h0005, 16'h0003, 1'b0, RES_GT);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accepted_busy", int'(busy), 1);
        hold_ok = 1;
        for (int t = 0; t < 4 * NDIG; t++) begin
            if (done) break;
            if ({eq, gt, lt} != RES_EQ) hold_ok = 0;
            @(negedge clk);
        end
        chk("b2b_hold_while_busy", hold_ok, 1);
        wait_done("b2b_second");
        @(negedge clk);

        // Reset in the second CMP cycle aborts the operation
        issue(16'h1111, 16'h1112, 1'b0, RES_LT);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midop_reset_outputs", int'({busy, done, eq, gt, lt}), 0);
        sb.delete();
        rst_n     = 1'b1;
        seen_done = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("no_done_after_abort", seen_done, 0);

        // Recovery after reset
        issue(16'h0001, 16'h0000, 1'b1, RES_GT);
        @(negedge clk);
        start = 1'b0;
        wait_done("after_reset");
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Parametrised multi-cycle magnitude comparator for WIDTH-bit operands.
- Scans DIGIT bits per clock, MSB first, with unsigned or signed (two's complement) mode selected per operation.
- Uses a start/busy/done handshake and holds eq/gt/lt results until the next completion.
- Serves datapaths where a wide single-cycle comparator would limit timing, or where comparator area must stay small.

Parameters:
- WIDTH, 16, operand width in bits; must be at least 2.
- DIGIT, 4, bits compared per cycle. WIDTH must be a multiple of DIGIT; otherwise elaboration fails with $error.
- NDIG, WIDTH/DIGIT, derived localparam: number of digits (not overridable).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- signed_mode  input  1  1 = two's complement compare, 0 = unsigned; captured with the operands.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse; eq/gt/lt are updated and valid in this cycle.
- eq  output  1  a == b.
- gt  output  1  a > b.
- lt  output  1  a < b.

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - busy, done, eq, gt, lt all go to 0; the digit index is cleared.
  - Reset mid-operation aborts the comparison: no done pulse, and the operation is lost.
- FSM states are IDLE and CMP. Registered outputs are eq/gt/lt plus done; busy is high exactly when the state is CMP.
- IDLE:
  - start=1 at an edge latches a, b and signed_mode, sets idx=0 and moves to CMP.
  - In signed mode the MSB of both captured operands is inverted, so the compare engine is always unsigned.
- CMP:
  - Each cycle compares digit idx (bits [WIDTH-1-idx*DIGIT -: DIGIT]) of the captured A and B.
  - If the digits differ (early exit), or idx == NDIG-1: on the edge, write gt/lt from that digit (eq=1 if all equal), set done=1, return to IDLE.
  - Otherwise idx increments.
- Latency:
  - done is high in the cycle after the deciding edge.
  - Counting edges from the start-accepting edge, the deciding edge is the (k+1)-th, where k is the index of the first differing digit, or NDIG-1 if the operands are equal.
- Outputs:
  - eq, gt and lt are one-hot whenever done has ever pulsed since reset.
  - They hold their values until the next done, including while busy.
- start while busy is ignored: no queuing and no error flag. Operand changes while busy have no effect.
- Back-to-back operation is allowed: start=1 during the done cycle (the state is IDLE) is accepted.
- start=0 in IDLE keeps the state at IDLE.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: early exit as described above, so latency depends on the data (1..NDIG cycles).
- Undefined:
  - Every operation takes exactly NDIG cycles in CMP.
  - The first differing digit's result is latched in an internal sticky "decided" register, and later digits are ignored.
  - Result values are identical to the defined case; only the timing differs (constant latency).

Decomposition:
- Package serial_cmp_pkg:
  - state enum typedef (IDLE, CMP).
  - Result-encoding localparams (RES_EQ, RES_GT, RES_LT) used by the bench checker.
- One sub-module, digit_compare: purely combinational, DIGIT-bit unsigned compare producing dig_eq and dig_gt. It is instantiated once inside the FSM module.

Test Plan (WIDTH=16, DIGIT=4):
- Equal operands: a=0x1234, b=0x1234, unsigned, start -> done 4 cycles after the start edge, eq=1, gt=0, lt=0.
- MSB difference: a=0x8000, b=0x7FFF.
  - Unsigned -> gt=1, done 1 cycle after start (early exit enabled), or 4 cycles after start (disabled).
  - Repeated with signed_mode=1 -> lt=1.
- Last-digit difference: a=0x00F0, b=0x00F1 -> lt=1, done 4 cycles after start in both builds. Negative signed pair 0xFFFE vs 0xFFFF -> lt=1.
- Start while busy: start with a=0x0001, b=0x0002, then start with a=0xFFFF, b=0x0000 one cycle later -> exactly one done; lt=1 (first operands); busy stays continuous.
- Reset mid-operation: rst_n=0 during the 2nd CMP cycle of a=0x1111, b=0x1112 -> next cycle busy=0, done=0, eq/gt/lt=0, and no later done pulse.
- Back-to-back: start asserted in the done cycle with a=0x0005, b=0x0003 -> accepted; the prior results hold until the new done, which then shows gt=1.
